// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the multicycle FP core controller.
// Pure definitions: no logic, no latency, no flow control.
package fp_ctrl_pkg;
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;
endpackage

// File: rtl/fp_valid_pipe.sv
// Valid+tag shift register tracking ops in flight through a fixed-latency core.
// DEPTH-cycle latency, shifts every cycle with no backpressure; synchronous active-low clear.
module fp_valid_pipe #(
   parameter int DEPTH = 6,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_vld,
   input  logic [TAG_W-1:0] in_tag,
   output logic [DEPTH-1:0] vld,
   output logic             out_vld,
   output logic [TAG_W-1:0] out_tag
);
   logic [TAG_W-1:0] tag_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) tag_sr[i] <= '0;
      end else begin
         vld[0]    <= in_vld;
         tag_sr[0] <= in_tag;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i]    <= vld[i-1];
            tag_sr[i] <= tag_sr[i-1];
         end
      end
   end

   assign out_vld = vld[DEPTH-1];
   assign out_tag = tag_sr[DEPTH-1];
endmodule

// File: rtl/fp_multicycle_ctrl.sv
// Controller for a fixed-latency clock-enabled FP core: blocking (stall-based) or pipelined issue.
// Result after LATENCY enabled edges; blocking mode stalls the issuer, pipelined mode never stalls.
module fp_multicycle_ctrl
   import fp_ctrl_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int LATENCY   = 6,
   parameter int TAG_W     = 4,
   parameter int PIPELINED = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             core_rst,
   output logic             core_en,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   input  logic [WIDTH-1:0] core_q,
   output logic [WIDTH-1:0] Q,
   output logic [TAG_W-1:0] q_tag,
   output logic             q_valid,
   output logic             stall,
   output logic             busy
);
   assign core_rst = ~reset;

   if (PIPELINED == 0) begin : g_blk
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

      state_t             state;
      logic [CNT_W-1:0]   cnt;
      logic [WIDTH-1:0]   a_r, b_r, hold_q;
      logic [TAG_W-1:0]   tag_r, hold_tag;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            tag_r    <= '0;
            hold_q   <= '0;
            hold_tag <= '0;
         end else begin
            case (state)
               IDLE: if (enable) begin
                  a_r   <= op_a;
                  b_r   <= op_b;
                  tag_r <= tag_in;
                  cnt   <= '0;
                  state <= WAIT;
               end
               WAIT: begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) state <= DONE;
               end
               DONE: begin
                  hold_q   <= core_q;
                  hold_tag <= tag_r;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end

      // Operands stay frozen in the regs for the whole op so the core sees stable inputs.
      assign core_en = reset & (state == WAIT);
      assign core_a  = a_r;
      assign core_b  = b_r;
      assign q_valid = reset & (state == DONE);
      assign Q       = !reset ? '0 : ((state == DONE) ? core_q : hold_q);
      assign q_tag   = !reset ? '0 : ((state == DONE) ? tag_r : hold_tag);
      assign stall   = reset & enable & (state != DONE);
      assign busy    = reset & ((state == WAIT) || (state == DONE));
   end else begin : g_pipe
      logic [LATENCY-1:0] vld;
      logic               tail_vld;
      logic [TAG_W-1:0]   tail_tag;
      logic [WIDTH-1:0]   hold_q;
      logic [TAG_W-1:0]   hold_tag;

      fp_valid_pipe #(
         .DEPTH (LATENCY),
         .TAG_W (TAG_W)
      ) u_valid_pipe (
         .clk     (clk),
         .reset   (reset),
         .in_vld  (enable),
         .in_tag  (tag_in),
         .vld     (vld),
         .out_vld (tail_vld),
         .out_tag (tail_tag)
      );

      always_ff @(posedge clk) begin
         if (!reset) begin
            hold_q   <= '0;
            hold_tag <= '0;
         end else if (tail_vld) begin
            hold_q   <= core_q;
            hold_tag <= tail_tag;
         end
      end

      assign core_en = reset;
      assign core_a  = op_a;
      assign core_b  = op_b;
      assign q_valid = reset & tail_vld;
      assign Q       = !reset ? '0 : (tail_vld ? core_q : hold_q);
      assign q_tag   = !reset ? '0 : (tail_vld ? tail_tag : hold_tag);
      assign stall   = 1'b0;
      assign busy    = reset & (|vld);
   end
endmodule

// File: tb/tb_fp_multicycle_ctrl.sv
// Bench for fp_multicycle_ctrl: blocking L=6, pipelined L=6 and blocking L=1 instances side by side.
module tb_fp_multicycle_ctrl;
   localparam int W  = 16;
   localparam int TW = 4;
   localparam int L  = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  op_a, op_b;
   logic [TW-1:0] tag_in;
   logic rst_b, rst_p, rst_1, en_b, en_p, en_1;

   logic          core_rst_b, core_en_b, q_valid_b, stall_b, busy_b;
   logic [W-1:0]  core_a_b, core_b_b, core_q_b, Q_b;
   logic [TW-1:0] q_tag_b;
   logic          core_rst_p, core_en_p, q_valid_p, stall_p, busy_p;
   logic [W-1:0]  core_a_p, core_b_p, core_q_p, Q_p;
   logic [TW-1:0] q_tag_p;
   logic          core_rst_1, core_en_1, q_valid_1, stall_1, busy_1;
   logic [W-1:0]  core_a_1, core_b_1, core_q_1, Q_1;
   logic [TW-1:0] q_tag_1;

   fp_multicycle_ctrl #(.WIDTH(W), .LATENCY(L), .TAG_W(TW), .PIPELINED(0)) dut_b (
      .clk(clk), .reset(rst_b), .enable(en_b), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
      .core_rst(core_rst_b), .core_en(core_en_b), .core_a(core_a_b), .core_b(core_b_b),
      .core_q(core_q_b), .Q(Q_b), .q_tag(q_tag_b), .q_valid(q_valid_b), .stall(stall_b), .busy(busy_b));

   fp_multicycle_ctrl #(.WIDTH(W), .LATENCY(L), .TAG_W(TW), .PIPELINED(1)) dut_p (
      .clk(clk), .reset(rst_p), .enable(en_p), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
      .core_rst(core_rst_p), .core_en(core_en_p), .core_a(core_a_p), .core_b(core_b_p),
      .core_q(core_q_p), .Q(Q_p), .q_tag(q_tag_p), .q_valid(q_valid_p), .stall(stall_p), .busy(busy_p));

   fp_multicycle_ctrl #(.WIDTH(W), .LATENCY(1), .TAG_W(TW), .PIPELINED(0)) dut_1 (
      .clk(clk), .reset(rst_1), .enable(en_1), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
      .core_rst(core_rst_1), .core_en(core_en_1), .core_a(core_a_1), .core_b(core_b_1),
      .core_q(core_q_1), .Q(Q_1), .q_tag(q_tag_1), .q_valid(q_valid_1), .stall(stall_1), .busy(busy_1));

   function automatic logic [W-1:0] fcore(input logic [W-1:0] a, input logic [W-1:0] b);
      return a + b - 16'h3C00;
   endfunction

   // Fixed-latency clock-enabled core models: result emerges after N enabled edges.
   logic [W-1:0] cm_b [L];
   logic [W-1:0] cm_p [L];
   logic [W-1:0] cm_1;

   always @(posedge clk) begin
      if (core_rst_b) for (int i = 0; i < L; i++) cm_b[i] <= '0;
      else if (core_en_b) begin
         cm_b[0] <= fcore(core_a_b, core_b_b);
         for (int i = 1; i < L; i++) cm_b[i] <= cm_b[i-1];
      end
   end
   always @(posedge clk) begin
      if (core_rst_p) for (int i = 0; i < L; i++) cm_p[i] <= '0;
      else if (core_en_p) begin
         cm_p[0] <= fcore(core_a_p, core_b_p);
         for (int i = 1; i < L; i++) cm_p[i] <= cm_p[i-1];
      end
   end
   always @(posedge clk) begin
      if (core_rst_1) cm_1 <= '0;
      else if (core_en_1) cm_1 <= fcore(core_a_1, core_b_1);
   end
   assign core_q_b = cm_b[L-1];
   assign core_q_p = cm_p[L-1];
   assign core_q_1 = cm_1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [TW-1:0] tag;
      int            drop_at;   // first cycle with enable low
      logic [W-1:0]  exp_q;
   } blk_vec_t;

   blk_vec_t vecs [4];

   task automatic blk_op(input blk_vec_t v);
      for (int c = 0; c <= L + 2; c++) begin
         en_b = (c < v.drop_at);
         if (c == 0) begin
            op_a = v.a; op_b = v.b; tag_in = v.tag;
         end else begin
            op_a = W'($urandom); op_b = W'($urandom); tag_in = TW'($urandom);
         end
         @(negedge clk);
         chk("blk_stall", stall_b, (c < v.drop_at) && (c <= L));
         chk("blk_qvalid", q_valid_b, c == L + 1);
         chk("blk_busy", busy_b, (c >= 1) && (c <= L + 1));
         chk("blk_core_en", core_en_b, (c >= 1) && (c <= L));
         if (c >= 1 && c <= L) chk("blk_core_a", core_a_b, v.a);
         if (c >= L + 1) begin
            chk("blk_q", Q_b, v.exp_q);
            chk("blk_qtag", q_tag_b, v.tag);
         end
         step();
      end
      en_b = 1'b0;
   endtask

   typedef struct {
      int            issue;
      logic [W-1:0]  q;
      logic [TW-1:0] tag;
   } pexp_t;

   pexp_t         pq [$];
   logic [W-1:0]  ph_q;
   logic [TW-1:0] ph_tag;

   // Reference: op issued at cycle t is in flight t+1..t+L and delivered at t+L, in order.
   task automatic pipe_run(input logic [63:0] pat, input int n, input bit rnd_tag);
      logic exp_v, exp_busy;
      for (int c = 0; c < n + L + 2; c++) begin
         en_p   = (c < n) && pat[c];
         op_a   = W'($urandom);
         op_b   = W'($urandom);
         tag_in = rnd_tag ? TW'($urandom) : TW'(c);
         if (en_p) pq.push_back('{c, fcore(op_a, op_b), tag_in});
         @(negedge clk);
         exp_v    = (pq.size() > 0) && (pq[0].issue + L == c);
         exp_busy = (pq.size() > 0) && (pq[0].issue < c);
         chk("pipe_stall", stall_p, 1'b0);
         chk("pipe_qvalid", q_valid_p, exp_v);
         chk("pipe_busy", busy_p, exp_busy);
         chk("pipe_core_a", core_a_p, op_a);
         if (exp_v) begin
            ph_q   = pq[0].q;
            ph_tag = pq[0].tag;
            void'(pq.pop_front());
         end
         chk("pipe_q", Q_p, ph_q);
         chk("pipe_qtag", q_tag_p, ph_tag);
         step();
      end
      en_p = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{16'h4000, 16'h3C00, 4'h5, 7, 16'h4000};
      vecs[1] = '{16'h1234, 16'h3C01, 4'hA, 3, 16'h1235};
      vecs[2] = '{16'hFFFF, 16'h3C02, 4'hF, 1, 16'h0001};
      vecs[3] = '{16'h0000, 16'h0000, 4'h0, 7, 16'hC400};
      ph_q = '0;
      ph_tag = '0;

      // Reset with enable asserted: every output must be forced quiet.
      rst_b = 1'b0; rst_p = 1'b0; rst_1 = 1'b0;
      en_b = 1'b1; en_p = 1'b1; en_1 = 1'b1;
      op_a = 16'h4000; op_b = 16'h3C00; tag_in = 4'h7;
      step();
      @(negedge clk);
      chk("rst_q_b", Q_b, 0);
      chk("rst_qtag_b", q_tag_b, 0);
      chk("rst_qvalid_b", q_valid_b, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_core_en_b", core_en_b, 0);
      chk("rst_stall_b", stall_b, 0);
      chk("rst_core_rst_b", core_rst_b, 1);
      chk("rst_q_p", Q_p, 0);
      chk("rst_qvalid_p", q_valid_p, 0);
      chk("rst_busy_p", busy_p, 0);
      chk("rst_core_en_p", core_en_p, 0);
      chk("rst_stall_1", stall_1, 0);
      chk("rst_busy_1", busy_1, 0);
      step();
      rst_b = 1'b1; rst_p = 1'b1; rst_1 = 1'b1;
      en_b = 1'b0; en_p = 1'b0; en_1 = 1'b0;
      @(negedge clk);
      chk("core_rst_released", core_rst_b, 0);
      chk("pipe_core_en_run", core_en_p, 1);
      step();

      for (int i = 0; i < 4; i++) blk_op(vecs[i]);

      // Back-to-back with enable held across DONE: one IDLE bubble between ops.
      for (int c = 0; c <= 16; c++) begin
         en_b = (c <= 15);
         if (c < 8) begin op_a = 16'h4000; op_b = 16'h3C00; tag_in = 4'h3; end
         else       begin op_a = 16'h1111; op_b = 16'h3C22; tag_in = 4'h9; end
         @(negedge clk);
         chk("b2b_stall", stall_b, (c <= 15) && (c != 7) && (c != 15));
         chk("b2b_qvalid", q_valid_b, (c == 7) || (c == 15));
         chk("b2b_busy", busy_b, ((c >= 1) && (c <= 7)) || ((c >= 9) && (c <= 15)));
         if (c == 7 || c == 8) begin
            chk("b2b_q1", Q_b, 16'h4000);
            chk("b2b_tag1", q_tag_b, 4'h3);
         end
         if (c >= 15) begin
            chk("b2b_q2", Q_b, 16'h1133);
            chk("b2b_tag2", q_tag_b, 4'h9);
         end
         step();
      end

      // Reset asserted in WAIT cycle 3: op abandoned, no result strobe.
      for (int c = 0; c <= 12; c++) begin
         en_b  = (c <= 3);
         rst_b = (c != 3);
         op_a = 16'h2222; op_b = 16'h3C00; tag_in = 4'h7;
         @(negedge clk);
         chk("rmid_qvalid", q_valid_b, 1'b0);
         chk("rmid_busy", busy_b, (c >= 1) && (c <= 2));
         chk("rmid_stall", stall_b, c <= 2);
         if (c >= 3) chk("rmid_q", Q_b, 16'h0000);
         if (c >= 4) chk("rmid_core_en", core_en_b, 1'b0);
         step();
      end
      en_b = 1'b0;

      // LATENCY=1 boundary: stall for exactly two cycles, DONE in cycle 2.
      for (int c = 0; c <= 3; c++) begin
         en_1 = (c <= 1);
         op_a = 16'h5000; op_b = 16'h3C01; tag_in = 4'hC;
         @(negedge clk);
         chk("l1_stall", stall_1, c <= 1);
         chk("l1_qvalid", q_valid_1, c == 2);
         chk("l1_busy", busy_1, (c == 1) || (c == 2));
         if (c >= 2) begin
            chk("l1_q", Q_1, 16'h5001);
            chk("l1_qtag", q_tag_1, 4'hC);
         end
         step();
      end
      en_1 = 1'b0;

      pipe_run(64'h3FF, 10, 1'b0);
      pipe_run(64'hD, 4, 1'b0);
      for (int r = 0; r < 4; r++) pipe_run({$urandom, $urandom}, 64, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_multicycle_ctrl.md
# fp_multicycle_ctrl

Parametrised controller for a fixed-latency, clock-enabled floating-point core (div, sqrt, or any vendor FP IP with an `en` input). It sits between the datapath issue stage and the core. It generates the pipeline `stall`, tags each operation, and presents a held result with a one-cycle `q_valid` strobe. Two modes are supported:
- **Blocking** (one op in flight, stall-based), the behaviour existing FP wrappers need.
- **Pipelined** (one op per cycle, no stall), for streaming use.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width.
- `LATENCY`, 6: number of enabled core clock edges from operand to valid `core_q`; legal range 1..15.
- `TAG_W`, 4: width of the per-op tag carried alongside the operation.
- `PIPELINED`, 0: selects the mode. 0 = blocking, 1 = pipelined.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `enable`  in  1  op request. Held high by the issuer until `stall` drops in blocking mode; one cycle per op in pipelined mode.
- `op_a`, `op_b`  in  WIDTH  operands.
- `tag_in`  in  TAG_W  op tag.
- `core_rst`  out  1  active-high core reset, equal to `~reset`.
- `core_en`  out  1  core clock enable.
- `core_a`, `core_b`  out  WIDTH  operands to the core.
- `core_q`  in  WIDTH  core result.
- `Q`  out  WIDTH  result.
- `q_tag`  out  TAG_W  tag of `Q`.
- `q_valid`  out  1  one-cycle result strobe.
- `stall`  out  1  issuer must hold the current instruction.
- `busy`  out  1  at least one op in flight.

## Operation
- **Reset** (`reset`=0 at an edge): state IDLE, counter 0, valid pipe cleared, hold regs 0. During reset, `Q`=0, `q_tag`=0, `q_valid`=0, `busy`=0, `core_en`=0, and `stall` is forced to 0. Reset mid-operation abandons the op; no `q_valid` is produced for it.

**Blocking mode** (`PIPELINED`=0): states IDLE, WAIT, DONE.
- **IDLE**:
  - If `enable`=1: latch `op_a`/`op_b`/`tag_in` into operand regs, clear the counter, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**: `core_en`=1, `core_a`/`core_b` come from the operand regs (stable for the whole op). The counter increments each cycle. At the edge where counter==LATENCY-1, go to DONE.
- **DONE**:
  - `core_en`=0, `q_valid`=1.
  - `Q` bypasses `core_q` and `q_tag` comes from the tag reg.
  - At the end of DONE the hold regs load `core_q`/tag, and the state goes to IDLE unconditionally.
- **Outputs outside DONE**: `Q`/`q_tag` come from the hold regs.
- **Stall**: `stall` = `enable` & (state != DONE), combinational. It is 1 in the IDLE request cycle and throughout WAIT.
- **Busy**: `busy`=1 in WAIT and DONE.
- **Back-to-back**: if `enable` is still high in the IDLE after DONE, it is a new op. The mandatory IDLE bubble is the decided behaviour.
- **Enable drop**: if `enable` drops during WAIT, the op completes anyway, with `stall`=0 and `q_valid` still pulsing.

**Pipelined mode** (`PIPELINED`=1):
- `core_en`=1 whenever `reset`=1. `core_a`/`core_b` = `op_a`/`op_b` directly.
- A valid+tag shift register of depth LATENCY shifts every cycle. Its input is `enable`/`tag_in`.
- `q_valid` = tail valid bit. `Q` = `core_q` when `q_valid`=1, else hold reg. The hold reg loads `core_q` when `q_valid`=1.
- `stall`=0 always. `busy` = OR of all valid bits.

## Timing
- **Blocking**: request seen in IDLE at cycle 0. WAIT occupies cycles 1..LATENCY, DONE is cycle LATENCY+1.
  - `stall` is high for LATENCY+1 cycles.
  - The next op can start no earlier than cycle LATENCY+2.
- **Pipelined**: op issued in cycle t gives `q_valid` in cycle t+LATENCY. Throughput is 1 op/cycle, and output order equals issue order.
- The counter width is 4 bits, with no wrap inside legal LATENCY.

## Structure
- `fp_ctrl_pkg`: state enum (IDLE=2'b00, WAIT=2'b01, DONE=2'b10), `LAT_MAX`=15, counter width constant.
- Sub-module `fp_valid_pipe`: parametrised (DEPTH, TAG_W) valid+tag shift register with synchronous active-low clear. It is used only in pipelined mode, selected by a generate on `PIPELINED`.
- The core itself is instantiated outside this block.

## Test plan
- **Blocking, single op**: LATENCY=6, `enable` held with A=0x4000, B=0x3C00, core model returns 0x4000 after 6 enabled edges. Required: `stall` high cycles 0..6, DONE at cycle 7 with `q_valid`=1, `Q`=0x4000, tag echoed; `Q` still 0x4000 in cycle 8.
- **Blocking, back-to-back**: `enable` kept high across DONE. Required: IDLE bubble at cycle 8, second WAIT starts cycle 9, second `q_valid` at cycle 15.
- **Reset mid-op**: `reset`=0 in WAIT cycle 3. Required: next cycle IDLE, `Q`=0, `stall`=0, `busy`=0, and no `q_valid` for the aborted op.
- **Pipelined stream**: LATENCY=6, ops issued cycles 0..9 with tags 0..9. Required: `stall`=0 throughout; `q_valid` in cycles 6..15 with `q_tag`=0..9 in order.
- **Pipelined gaps**: ops at cycles 0, 2, 3. Required: `q_valid` exactly at cycles 6, 8, 9; `busy` falls after cycle 9.
- **Boundary LATENCY=1, blocking**: `stall` high exactly 2 cycles; DONE at cycle 2.
